// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional misaligned-PC trapping is enabled by defining FETCH_MISALIGN_EN.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        misalign;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INST = 32'h00000013;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetch entries between fetch and decode.
// Registered head output, clear has priority over push/pop, async active-high reset.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  fetch_entry_t           push_entry_i,
   input  logic                   pop_i,
   output fetch_entry_t           head_o,
   output logic                   valid_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full queue is only legal when the head leaves on the same edge.
   assign do_pop  = pop_i & (count_q != '0);
   assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, PC-tagged queue toward decode, flush support.
// Define FETCH_MISALIGN_EN to turn misaligned PCs into tagged NOP entries instead of memory requests.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          QUEUE_DEPTH = 2,
   parameter logic [31:0] RESET_INST  = NOP_INST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        flush,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_misalign,
   input  logic        if_ready
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      pending_pc_q;
   logic [CNT_W-1:0] q_count;
   logic             q_valid;
   fetch_entry_t     q_head;
   fetch_entry_t     push_entry;
   logic             space_avail;
   logic             can_issue;
   logic             pc_misaligned;
   logic             req_fire;
   logic             resp_push;
   logic             misalign_push;

`ifdef FETCH_MISALIGN_EN
   assign pc_misaligned = (pc_in[1:0] != 2'b00);
`else
   assign pc_misaligned = 1'b0;
`endif

   // Issuing only from IDLE with a free slot keeps count + outstanding within the queue depth.
   assign space_avail    = (q_count < CNT_W'(QUEUE_DEPTH));
   assign can_issue      = ~reset & pc_valid & (state_q == IDLE) & ~flush & space_avail;
   assign imem_req_valid = can_issue & ~pc_misaligned;
   assign misalign_push  = can_issue & pc_misaligned;
   assign req_fire       = imem_req_valid & imem_req_ready;
   assign pc_ready       = req_fire | misalign_push;
   assign imem_req_addr  = word_align(pc_in);
   assign resp_push      = (state_q == WAIT) & imem_resp_valid & ~flush;

   always_comb begin
      push_entry = '0;
      if (resp_push) begin
         push_entry.pc   = pending_pc_q;
         push_entry.inst = imem_resp_data;
      end else begin
         push_entry.pc       = pc_in;
         push_entry.inst     = RESET_INST;
         push_entry.misalign = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_fire) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A response always closes the transaction; flush only decides whether it is kept.
            if (imem_resp_valid) begin
               state_d = IDLE;
            end else if (flush) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (imem_resp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) begin
         pending_pc_q <= word_align(pc_in);
      end
   end

   fetch_queue #(
      .DEPTH(QUEUE_DEPTH)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (flush),
      .push_i       (resp_push | misalign_push),
      .push_entry_i (push_entry),
      .pop_i        (if_ready),
      .head_o       (q_head),
      .valid_o      (q_valid),
      .count_o      (q_count)
   );

   assign if_valid = q_valid;
   assign if_inst  = q_valid ? q_head.inst : RESET_INST;
   assign if_pc    = q_valid ? q_head.pc : 32'h0;

`ifdef FETCH_MISALIGN_EN
   assign if_misalign = q_valid & q_head.misalign;
`else
   logic unused_misalign;
   assign unused_misalign = q_head.misalign;
   assign if_misalign     = 1'b0;
`endif

`ifndef SYNTHESIS
   resp_without_request_a : assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && (state_q == IDLE)))
      else $error("imem_resp_valid seen with no request outstanding");
`endif

endmodule
